// File: rtl/checker_pkg.sv
// rtl/checker_pkg.sv - shared state encodings and width helper for the exhaustive checker
package checker_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_APPLY = 2'd1;
  localparam state_t ST_CHECK = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // err_count must hold 2^k, one more bit than the vector itself
  function automatic int err_width(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/sweep_counter.sv
// rtl/sweep_counter.sv - vector counter plus per-vector settle down-counter
module sweep_counter #(
  parameter int K      = 5,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         advance,
  input  logic         settle_dec,
  output logic [K-1:0] vec,
  output logic         settle_zero,
  output logic         vec_last
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] RELOAD = SW'(SETTLE - 1);

  logic [SW-1:0] settle_cnt;

  // clear starts a sweep at vector 0; advance steps the vector and re-arms the settle wait
  always_ff @(posedge clk) begin
    if (reset) begin
      vec        <= '0;
      settle_cnt <= '0;
    end else if (clear) begin
      vec        <= '0;
      settle_cnt <= RELOAD;
    end else if (advance) begin
      vec        <= vec + 1'b1;
      settle_cnt <= RELOAD;
    end else if (settle_dec) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  assign settle_zero = (settle_cnt == '0);
  assign vec_last    = &vec;

endmodule

// File: rtl/exhaustive_checker.sv
// rtl/exhaustive_checker.sv - sweep all 2^K vectors and compare reference vs reduced outputs
module exhaustive_checker
  import checker_pkg::*;
#(
  parameter int K      = 5,
  parameter int M      = 4,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop_on_fail,
  input  logic [M-1:0]            ref_out,
  input  logic [M-1:0]            dut_out,
  output logic [K-1:0]            vec,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [err_width(K)-1:0] err_count,
  output logic [K-1:0]            first_fail_vec,
  output logic [M-1:0]            first_fail_mask,
  output logic [M-1:0]            fail_mask_acc
);

  state_t       state, state_n;
  logic         clr, adv, dec;
  logic         settle_zero, vec_last;
  logic         sof_l, ff_flag;
  logic [M-1:0] mis;

  sweep_counter #(.K(K), .SETTLE(SETTLE)) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .clear       (clr),
    .advance     (adv),
    .settle_dec  (dec),
    .vec         (vec),
    .settle_zero (settle_zero),
    .vec_last    (vec_last)
  );

  assign mis = ref_out ^ dut_out;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // next state and counter controls; start is only honoured when not busy
  always_comb begin
    state_n = state;
    clr     = 1'b0;
    adv     = 1'b0;
    dec     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clr     = 1'b1;
          state_n = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (settle_zero) state_n = ST_CHECK;
        else             dec     = 1'b1;
      end
      ST_CHECK: begin
        if (vec_last || (sof_l && (mis != '0))) begin
          state_n = ST_DONE;
        end else begin
          adv     = 1'b1;
          state_n = ST_APPLY;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // result registers: cleared on launch, updated on every mismatching CHECK
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      err_count       <= '0;
      first_fail_vec  <= '0;
      first_fail_mask <= '0;
      fail_mask_acc   <= '0;
      ff_flag         <= 1'b0;
      sof_l           <= reset ? 1'b0 : stop_on_fail;
    end else if ((state == ST_CHECK) && (mis != '0)) begin
      err_count     <= err_count + 1'b1;
      fail_mask_acc <= fail_mask_acc | mis;
      if (!ff_flag) begin
        first_fail_vec  <= vec;
        first_fail_mask <= mis;
        ff_flag         <= 1'b1;
      end
    end
  end

  assign busy = (state == ST_APPLY) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_exhaustive_checker.sv
// tb/tb_exhaustive_checker.sv - randomized self-checking bench for exhaustive_checker
module tb_exhaustive_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start_i, sof, sel;
  int         mode;
  logic [3:0] rtab [32];
  int         checks = 0;
  int         failures = 0;

  logic [4:0] vec_a;  logic [5:0] err_a;  logic [4:0] ffv_a;
  logic [2:0] vec_b;  logic [3:0] err_b;  logic [2:0] ffv_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [3:0] ffm_a, acc_a, ref_a, dut_a, ffm_b, acc_b, ref_b, dut_b;

  function automatic logic [3:0] f_ref(input int v);
    return 4'(v * 5 + (v >> 2) + 3);
  endfunction

  function automatic logic [3:0] mask_of(input int md, input int v);
    case (md)
      1:       return (v == 13) ? 4'b0100 : 4'b0000;
      2:       return (v == 7 || v == 20) ? 4'b0001 : 4'b0000;
      3:       return 4'hF;
      4:       return rtab[v];
      default: return 4'b0000;
    endcase
  endfunction

  assign ref_a = f_ref(int'(vec_a));
  assign dut_a = ref_a ^ mask_of(mode, int'(vec_a));
  assign ref_b = f_ref(int'(vec_b));
  assign dut_b = ref_b ^ mask_of(mode, int'(vec_b));

  exhaustive_checker #(.K(5), .M(4), .SETTLE(1)) dut_a5 (
    .clk(clk), .reset(reset), .start(start_i & ~sel), .stop_on_fail(sof),
    .ref_out(ref_a), .dut_out(dut_a), .vec(vec_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .first_fail_vec(ffv_a),
    .first_fail_mask(ffm_a), .fail_mask_acc(acc_a)
  );

  exhaustive_checker #(.K(3), .M(4), .SETTLE(2)) dut_b3 (
    .clk(clk), .reset(reset), .start(start_i & sel), .stop_on_fail(sof),
    .ref_out(ref_b), .dut_out(dut_b), .vec(vec_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .first_fail_vec(ffv_b),
    .first_fail_mask(ffm_b), .fail_mask_acc(acc_b)
  );

  logic [31:0] o_vec, o_err, o_ffv, o_ffm, o_acc;
  logic        o_busy, o_done, o_pass;
  assign o_vec  = sel ? 32'(vec_b) : 32'(vec_a);
  assign o_err  = sel ? 32'(err_b) : 32'(err_a);
  assign o_ffv  = sel ? 32'(ffv_b) : 32'(ffv_a);
  assign o_ffm  = sel ? 32'(ffm_b) : 32'(ffm_a);
  assign o_acc  = sel ? 32'(acc_b) : 32'(acc_a);
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_pass = sel ? pass_b : pass_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_vec"},  o_vec, 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_pass"}, 32'(o_pass), 0);
    chk({tag, "_err"},  o_err, 0);
    chk({tag, "_ffv"},  o_ffv, 0);
    chk({tag, "_ffm"},  o_ffm, 0);
    chk({tag, "_acc"},  o_acc, 0);
  endtask

  // Model: walk the truth table, apply the stop rule, derive results and timing.
  task automatic run_sweep(input int k, input int s, input int md, input bit so,
                           input int start_at, input int reset_at);
    int  cnt, acc, ffv, ffm, endv, expc;
    bit  first;
    logic [3:0] m;
    cnt = 0; acc = 0; ffv = 0; ffm = 0; first = 1'b1; endv = (1 << k) - 1;
    for (int v = 0; v < (1 << k); v++) begin
      m = mask_of(md, v);
      if (m != 0) begin
        cnt++;
        acc |= int'(m);
        if (first) begin ffv = v; ffm = int'(m); first = 1'b0; end
        if (so) begin endv = v; break; end
      end
    end
    expc = (endv + 1) * (s + 1);

    mode = md;
    @(negedge clk);
    start_i = 1'b1;
    sof     = so;
    @(posedge clk);
    #1 start_i = 1'b0;
    sof = ~so;
    chk("launch_busy", 32'(o_busy), 1);
    chk("launch_done", 32'(o_done), 0);
    chk("launch_err",  o_err, 0);
    chk("launch_acc",  o_acc, 0);
    chk("launch_ffm",  o_ffm, 0);
    chk("launch_vec",  o_vec, 0);

    for (int n = 1; n <= expc; n++) begin
      @(posedge clk);
      #1;
      if (reset_at >= 0 && n == reset_at + 1) begin
        reset = 1'b0;
        check_cleared("midreset");
        return;
      end
      if (n == expc) begin
        chk("done_at_edge", 32'(o_done), 1);
      end else begin
        chk("not_done_yet", 32'(o_done), 0);
        chk("vec_step", o_vec, 32'(n / (s + 1)));
      end
      start_i = (n == start_at);
      reset   = (n == reset_at);
    end

    chk("pass", 32'(o_pass), (cnt == 0) ? 1 : 0);
    chk("err_count", o_err, 32'(cnt));
    chk("first_fail_vec", o_ffv, 32'(ffv));
    chk("first_fail_mask", o_ffm, 32'(ffm));
    chk("fail_mask_acc", o_acc, 32'(acc));
    chk("final_vec", o_vec, 32'(endv));
    repeat (3) @(posedge clk);
    #1;
    chk("done_holds", 32'(o_done), 1);
    chk("vec_holds", o_vec, 32'(endv));
    chk("err_holds", o_err, 32'(cnt));
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; sof = 1'b0; sel = 1'b0; mode = 0;
    for (int i = 0; i < 32; i++) rtab[i] = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset_a");
    sel = 1'b1;
    #1;
    check_cleared("reset_b");
    reset = 1'b0;
    sel   = 1'b0;

    run_sweep(5, 1, 0, 1'b0, -1, -1);
    run_sweep(5, 1, 1, 1'b0, -1, -1);
    run_sweep(5, 1, 2, 1'b1, -1, -1);
    run_sweep(5, 1, 3, 1'b0, -1, -1);
    for (int i = 0; i < 32; i++)
      rtab[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
    run_sweep(5, 1, 4, 1'b0, -1, -1);
    for (int i = 0; i < 32; i++)
      rtab[i] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
    run_sweep(5, 1, 4, 1'b1, -1, -1);
    run_sweep(5, 1, 3, 1'b0, 10, 20);
    run_sweep(5, 1, 0, 1'b0, -1, -1);

    sel = 1'b1;
    run_sweep(3, 2, 3, 1'b0, -1, -1);
    run_sweep(3, 2, 0, 1'b0, -1, -1);
    for (int i = 0; i < 32; i++) rtab[i] = 4'($urandom_range(0, 15));
    rtab[5] = 4'b1010;
    run_sweep(3, 2, 4, 1'b1, -1, -1);
    run_sweep(3, 2, 4, 1'b0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exhaustive_checker.md
Name: exhaustive_checker

Overview:
- Synthesisable sweep-and-compare engine that drives every one of the 2^K input combinations onto a shared vector bus.
- Compares M reference outputs (original expressions) against M candidate outputs (Karnaugh-reduced expressions), per vector.
- Moves the exhaustive truth-table equivalence check into hardware. Sits beside the pair of function blocks under test; results are readable on board or in simulation.
- Generalises the fixed 5-input / 4-function sweep to parametric input width, channel count and settle time, and adds mismatch counting, first-failure capture and a stop-on-fail mode.

Parameters:
- K, 5, input vector width; the sweep covers 0 .. 2^K-1.
- M, 4, number of output channels compared.
- SETTLE, 1, cycles each vector is held before sampling; legal range is SETTLE >= 1.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high; forces IDLE and clears every output.
- start  in  1  sampled in IDLE or DONE only; launches a sweep.
- stop_on_fail  in  1  sampled with start; 1 ends the sweep at the first mismatching vector.
- ref_out  in  M  reference function outputs for the current vec.
- dut_out  in  M  reduced function outputs for the current vec.
- vec  out  K  input vector driven to both function blocks, e.g. {A,B,C,D,E} = vec.
- busy  out  1  high in APPLY and CHECK.
- done  out  1  high in DONE (level).
- pass  out  1  high in DONE when err_count == 0.
- err_count  out  K+1  number of vectors with at least one mismatching channel.
- first_fail_vec  out  K  vec of the first mismatch.
- first_fail_mask  out  M  ref_out ^ dut_out at the first mismatch.
- fail_mask_acc  out  M  running OR of ref_out ^ dut_out across the sweep.

Behaviour:
- Reset value of every output is 0. Reset wins over all other inputs on the same edge.
- States: IDLE, APPLY, CHECK, DONE.
- IDLE:
  - start=1 clears vec, err_count, first_fail_*, fail_mask_acc and the internal first-fail flag.
  - It latches stop_on_fail, loads settle_cnt = SETTLE-1 and goes to APPLY.
- APPLY:
  - vec is held stable.
  - Go to CHECK when settle_cnt == 0; otherwise decrement settle_cnt.
- CHECK: compute mis = ref_out ^ dut_out.
  - If mis != 0:
    - err_count increments.
    - fail_mask_acc |= mis.
    - If this is the first mismatch: first_fail_vec = vec, first_fail_mask = mis, set the first-fail flag.
  - Go to DONE if vec == 2^K-1, or if latched stop_on_fail == 1 and mis != 0.
  - Otherwise vec increments, settle_cnt reloads, and the state returns to APPLY.
- DONE:
  - done=1 and pass = (err_count == 0).
  - vec and all results hold.
  - start=1 behaves as in IDLE and begins a new sweep; done falls on that edge.
- start while busy is ignored.
- stop_on_fail changes mid-sweep are ignored.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - With start sampled at edge e0, a full sweep reaches DONE at edge e0 + 2^K*(SETTLE+1).
  - A stop on vector v reaches DONE at edge e0 + (v+1)*(SETTLE+1).
- err_count cannot exceed 2^K, so it never overflows; no saturation logic is needed.
- vec does not wrap. The terminal compare prevents an increment past 2^K-1.
- Reset mid-sweep: the next cycle shows IDLE, vec=0, busy=0 and all results 0.

Decomposition:
- Shared package/header checker_pkg holds:
  - the state encodings (2-bit localparams ST_IDLE, ST_APPLY, ST_CHECK, ST_DONE);
  - the derived width macro for err_count (K+1).
- One sub-module, sweep_counter (K-bit vector counter plus settle down-counter, with clear, advance and terminal-flag outputs). The FSM and result registers stay in exhaustive_checker.

Test Plan (K=5, M=4, SETTLE=1 unless noted):
- Equivalent functions (dut_out = ref_out = combinational f(vec)), start pulse -> done at edge e0+64; pass=1, err_count=0, fail_mask_acc=4'b0000, vec=31.
- dut_out channel 2 inverted only at vec=13 -> done at e0+64; err_count=1, first_fail_vec=13, first_fail_mask=4'b0100, fail_mask_acc=4'b0100, pass=0.
- stop_on_fail=1, channel 0 mismatches at vec=7 and vec=20 -> done at e0+16; err_count=1, first_fail_vec=7, vec holds 7.
- dut_out = ~ref_out for every vector -> err_count=32, first_fail_vec=0, first_fail_mask=4'hF, fail_mask_acc=4'hF.
- Assert start again at vec=5 (ignored, sweep continues); assert reset for one cycle at vec=10 -> next cycle vec=0, busy=0, done=0, err_count=0; a new start then completes normally.
- K=3, SETTLE=2: start from DONE restarts the sweep -> results cleared on the start edge, done again at e0+24, with vec stepping every 3 cycles.
